// File: rtl/dmem_latency_ctrl_pkg.sv
// Shared definitions for the data-memory latency controller: RV32I load/store
// size codes, controller states and the byte-enable helper.
package dmem_latency_ctrl_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Lanes touched by an access of the given size starting at byte offset off.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_latency_ctrl_if.sv
// M-stage to data-memory bus: request, store data, load response, stall/error
// handshake and the MMIO output register value.
interface dmem_latency_ctrl_if;

  logic        memread_M;
  logic        memwrite_M;
  logic [2:0]  funct3_M;
  logic [31:0] data_adr;
  logic [31:0] writedata_M;
  logic [31:0] readdata_M;
  logic        stall_M;
  logic        err_M;
  logic [31:0] io_out;

  modport master (
    output memread_M, memwrite_M, funct3_M, data_adr, writedata_M,
    input  readdata_M, stall_M, err_M, io_out
  );

  modport slave (
    input  memread_M, memwrite_M, funct3_M, data_adr, writedata_M,
    output readdata_M, stall_M, err_M, io_out
  );

endinterface

// File: rtl/dmem_latency_ctrl_lane_align.sv
// Combinational lane steering: store data replication and byte enables, load
// lane selection with sign/zero extension, and misaligned/illegal detection.
module dmem_latency_ctrl_lane_align
  import dmem_latency_ctrl_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic        i_store,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_be,
  output logic        o_err,
  output logic [31:0] o_rdata
);

  logic        w_legal;
  logic        w_misal;
  logic [31:0] w_shift;

  // Unsigned load codes have no store counterpart, so they are illegal for stores.
  always_comb begin
    w_legal = 1'b0;
    case (i_funct3)
      F3_B, F3_H, F3_W: w_legal = 1'b1;
      F3_BU, F3_HU:     w_legal = ~i_store;
      default:          w_legal = 1'b0;
    endcase
    w_misal = ((i_funct3[1:0] == 2'b01) && i_off[0]) ||
              ((i_funct3[1:0] == 2'b10) && (i_off != 2'b00));
    o_err   = ~w_legal | w_misal;
    if (o_err) begin
      o_be = 4'b0000;
    end else begin
      o_be = byte_en(i_funct3[1:0], i_off);
    end
  end

  always_comb begin
    o_wdata = i_wdata;
    case (i_funct3[1:0])
      2'b00:   o_wdata = {4{i_wdata[7:0]}};
      2'b01:   o_wdata = {2{i_wdata[15:0]}};
      default: o_wdata = i_wdata;
    endcase
  end

  always_comb begin
    w_shift = i_rword >> {i_off, 3'b000};
    o_rdata = 32'd0;
    case (i_funct3)
      F3_B:    o_rdata = {{24{w_shift[7]}}, w_shift[7:0]};
      F3_H:    o_rdata = {{16{w_shift[15]}}, w_shift[15:0]};
      F3_W:    o_rdata = w_shift;
      F3_BU:   o_rdata = {24'd0, w_shift[7:0]};
      F3_HU:   o_rdata = {16'd0, w_shift[15:0]};
      default: o_rdata = 32'd0;
    endcase
  end

endmodule

// File: rtl/dmem_latency_ctrl.sv
// Data memory with configurable wait states: stall handshake toward the M stage,
// sub-word loads/stores, access-error pulse and one memory-mapped output register.
module dmem_latency_ctrl
  import dmem_latency_ctrl_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] IO_ADDR     = 32'h0000_0400
) (
  input  logic               clk,
  input  logic               reset,
  dmem_latency_ctrl_if.slave bus
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  state_e      r_state;
  state_e      w_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;
  logic [31:0] r_io;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_req;
  logic          w_store;
  logic          w_io_hit;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rword;
  logic [31:0]   w_wdata;
  logic [3:0]    w_be;
  logic          w_align_err;
  logic [31:0]   w_load;
  logic          w_complete;
  logic          w_stall;
  logic          w_err;
  logic [31:0]   w_rdata;
  logic          w_ram_we;
  logic          w_io_we;

  assign w_req    = bus.memread_M | bus.memwrite_M;
  assign w_store  = bus.memwrite_M;
  assign w_io_hit = (bus.data_adr[31:2] == IO_ADDR[31:2]);
  assign w_idx    = bus.data_adr[AW+1:2];

  always_comb begin
    if (w_io_hit) begin
      w_rword = r_io;
    end else begin
      w_rword = r_mem[w_idx];
    end
  end

  dmem_latency_ctrl_lane_align u_align (
    .i_funct3 (bus.funct3_M),
    .i_off    (bus.data_adr[1:0]),
    .i_store  (w_store),
    .i_wdata  (bus.writedata_M),
    .i_rword  (w_rword),
    .o_wdata  (w_wdata),
    .o_be     (w_be),
    .o_err    (w_align_err),
    .o_rdata  (w_load)
  );

  // State and wait counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // DONE always returns to IDLE so a request still held in its completion cycle is not re-accepted.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_req && (LATENCY > 0)) begin
          if (LATENCY == 1) begin
            w_next = DONE;
          end else begin
            w_next     = BUSY;
            w_cnt_next = CNT_INIT;
          end
        end else begin
          w_next = IDLE;
        end
      end
      BUSY: begin
        if (!w_req) begin
          w_next     = IDLE;
          w_cnt_next = 4'd0;
        end else if (r_cnt == 4'd0) begin
          w_next = DONE;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      DONE: begin
        w_next     = IDLE;
        w_cnt_next = 4'd0;
      end
      default: begin
        w_next     = IDLE;
        w_cnt_next = 4'd0;
      end
    endcase
  end

  // Handshake outputs; reset forces everything quiet even with a request held.
  always_comb begin
    w_stall    = 1'b0;
    w_complete = 1'b0;
    if (!reset && w_req) begin
      case (r_state)
        IDLE: begin
          w_stall    = (LATENCY > 0);
          w_complete = (LATENCY == 0);
        end
        BUSY: begin
          w_stall    = 1'b1;
          w_complete = 1'b0;
        end
        DONE: begin
          w_stall    = 1'b0;
          w_complete = 1'b1;
        end
        default: begin
          w_stall    = 1'b0;
          w_complete = 1'b0;
        end
      endcase
    end else begin
      w_stall    = 1'b0;
      w_complete = 1'b0;
    end
  end

  always_comb begin
    w_err    = w_complete & w_align_err;
    w_ram_we = w_complete & w_store & ~w_align_err & ~w_io_hit;
    w_io_we  = w_complete & w_store & ~w_align_err & w_io_hit;
    if (w_complete && !w_store && !w_align_err) begin
      w_rdata = w_load;
    end else begin
      w_rdata = 32'd0;
    end
  end

  // MMIO output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_io <= 32'd0;
    end else if (w_io_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_io[i*8 +: 8] <= w_wdata[i*8 +: 8];
        end
      end
    end
  end

  // Word RAM, contents deliberately not reset
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][i*8 +: 8] <= w_wdata[i*8 +: 8];
        end
      end
    end
  end

  assign bus.readdata_M = w_rdata;
  assign bus.stall_M    = w_stall;
  assign bus.err_M      = w_err;
  assign bus.io_out     = r_io;

endmodule

// File: tb/tb_dmem_latency_ctrl.sv
// Randomised bench for dmem_latency_ctrl (LATENCY=2 and LATENCY=0 instances)
// against a transaction-level memory model kept in the bench.
module tb_dmem_latency_ctrl;

  localparam logic [31:0] IO_ADDR = 32'h0000_0400;
  localparam int          LAT_A   = 2;

  logic clk;
  logic reset;

  dmem_latency_ctrl_if if_a ();
  dmem_latency_ctrl_if if_b ();

  dmem_latency_ctrl #(.DEPTH_WORDS(256), .LATENCY(LAT_A), .IO_ADDR(IO_ADDR)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (if_a)
  );

  dmem_latency_ctrl #(.DEPTH_WORDS(256), .LATENCY(0), .IO_ADDR(IO_ADDR)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          sel      = 0;
  logic        exp_on   = 1'b0;
  logic        exp_stall, exp_err;
  logic [31:0] exp_rd;
  logic [31:0] m_mem [2][256];
  logic [31:0] m_io  [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (dut %0d, t=%0t): got %h, expected %h", name, sel, $time, act, exp);
    end
  endtask

  // Reference: result of one whole access computed from the load/store rules.
  function automatic void model_access(input int s, input logic wr, input logic [2:0] f3,
                                       input logic [31:0] adr, input logic [31:0] wd,
                                       output logic [31:0] rdata, output logic err,
                                       output logic [31:0] nw, output logic st_ok,
                                       output logic io_hit);
    int n;
    int off;
    logic [31:0] old;
    logic [31:0] v;
    logic [31:0] mask;
    case (f3)
      3'd0, 3'd4: n = 1;
      3'd1, 3'd5: n = 2;
      3'd2:       n = 4;
      default:    n = 0;
    endcase
    if (wr && f3[2]) n = 0;
    off    = int'(adr[1:0]);
    err    = (n == 0) ? 1'b1 : ((off % n) != 0);
    io_hit = (adr[31:2] == IO_ADDR[31:2]);
    old    = io_hit ? m_io[s] : m_mem[s][adr[9:2]];
    rdata  = 32'd0;
    nw     = old;
    st_ok  = 1'b0;
    if (wr) begin
      if (!err) begin
        for (int i = 0; i < n; i++) nw[(off+i)*8 +: 8] = wd[i*8 +: 8];
        st_ok = 1'b1;
      end
    end else if (!err) begin
      v = old >> (off * 8);
      if (n < 4) begin
        mask = (32'd1 << (n * 8)) - 32'd1;
        v    = v & mask;
        if (!f3[2] && v[n*8-1]) v = v | ~mask;
      end
      rdata = v;
    end
  endfunction

  task automatic set_req(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] adr, input logic [31:0] wd);
    if (sel == 0) begin
      if_a.memread_M = rd; if_a.memwrite_M = wr; if_a.funct3_M = f3;
      if_a.data_adr = adr; if_a.writedata_M = wd;
    end else begin
      if_b.memread_M = rd; if_b.memwrite_M = wr; if_b.funct3_M = f3;
      if_b.data_adr = adr; if_b.writedata_M = wd;
    end
  endtask

  task automatic idle_cycle();
    set_req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    exp_stall = 1'b0; exp_err = 1'b0; exp_rd = 32'd0;
    @(posedge clk); #1;
  endtask

  // One access: request stays stable for LATENCY+1 cycles unless flushed at cycle flush_at.
  task automatic xact(input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] adr, input logic [31:0] wd, input int flush_at,
                      input bit lit_chk, input logic [31:0] lit_rd, input logic lit_err);
    logic [31:0] r_exp, nw;
    logic        e_exp, st_ok, io_hit;
    int          lat;
    lat = (sel == 0) ? LAT_A : 0;
    model_access(sel, wr, f3, adr, wd, r_exp, e_exp, nw, st_ok, io_hit);
    if (lit_chk) begin
      check("model_rdata_literal", r_exp, lit_rd);
      check("model_err_literal", {31'd0, e_exp}, {31'd0, lit_err});
    end
    set_req(rd, wr, f3, adr, wd);
    for (int k = 0; k <= lat; k++) begin
      if (k == flush_at) begin
        idle_cycle();
        return;
      end
      exp_stall = (k < lat);
      exp_err   = (k == lat) ? e_exp : 1'b0;
      exp_rd    = (k == lat) ? r_exp : 32'd0;
      @(posedge clk); #1;
    end
    if (st_ok) begin
      if (io_hit) m_io[sel] = nw;
      else        m_mem[sel][adr[9:2]] = nw;
    end
  endtask

  task automatic reset_mid_store(input logic [31:0] adr, input logic [31:0] wd);
    set_req(1'b0, 1'b1, 3'd2, adr, wd);
    exp_stall = 1'b1; exp_err = 1'b0; exp_rd = 32'd0;
    @(posedge clk); #1;
    reset = 1'b1;
    m_io[0] = 32'd0; m_io[1] = 32'd0;
    exp_stall = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    idle_cycle();
  endtask

  task automatic random_phase(input int count);
    logic [2:0]  sf [6];
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] adr;
    int          kind, r, fl;
    sf = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
    for (int n = 0; n < count; n++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        idle_cycle();
      end else begin
        rd  = (kind <= 4) || (kind == 9);
        wr  = (kind >= 5);
        f3  = wr ? sf[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
        r   = $urandom_range(0, 15);
        if (r == 0)     adr = $urandom;
        else if (r < 3) adr = IO_ADDR | 32'($urandom_range(0, 3));
        else            adr = 32'($urandom_range(0, 4095));
        fl  = ((sel == 0) && ($urandom_range(0, 15) == 0)) ? 1 : -1;
        xact(rd, wr, f3, adr, $urandom, fl, 1'b0, 32'd0, 1'b0);
      end
    end
    idle_cycle();
  endtask

  // Compare process: DUT outputs against the model expectations every cycle.
  always @(negedge clk) begin
    if (exp_on) begin
      if (sel == 0) begin
        check("stall_M", {31'd0, if_a.stall_M}, {31'd0, exp_stall});
        check("err_M", {31'd0, if_a.err_M}, {31'd0, exp_err});
        check("readdata_M", if_a.readdata_M, exp_rd);
        check("io_out", if_a.io_out, m_io[0]);
      end else begin
        check("stall_M", {31'd0, if_b.stall_M}, {31'd0, exp_stall});
        check("err_M", {31'd0, if_b.err_M}, {31'd0, exp_err});
        check("readdata_M", if_b.readdata_M, exp_rd);
        check("io_out", if_b.io_out, m_io[1]);
      end
    end
  end

  initial begin
    reset = 1'b1;
    exp_stall = 1'b0; exp_err = 1'b0; exp_rd = 32'd0;
    m_io[0] = 32'd0; m_io[1] = 32'd0;
    sel = 1; set_req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    sel = 0; set_req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    @(posedge clk); #1;
    exp_on = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    idle_cycle();

    for (int i = 0; i < 256; i++) xact(1'b0, 1'b1, 3'd2, 32'(i * 4), $urandom, -1, 1'b0, 32'd0, 1'b0);

    xact(1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, -1, 1'b1, 32'd0, 1'b0);
    xact(1'b1, 1'b0, 3'd2, 32'h10, 32'd0, -1, 1'b1, 32'hDEADBEEF, 1'b0);
    xact(1'b0, 1'b1, 3'd2, 32'h10, 32'd0, -1, 1'b0, 32'd0, 1'b0);
    xact(1'b0, 1'b1, 3'd0, 32'h11, 32'h0000007F, -1, 1'b0, 32'd0, 1'b0);
    xact(1'b1, 1'b0, 3'd2, 32'h10, 32'd0, -1, 1'b1, 32'h00007F00, 1'b0);
    xact(1'b1, 1'b0, 3'd0, 32'h11, 32'd0, -1, 1'b1, 32'h0000007F, 1'b0);
    xact(1'b0, 1'b1, 3'd0, 32'h12, 32'h00000080, -1, 1'b0, 32'd0, 1'b0);
    xact(1'b1, 1'b0, 3'd0, 32'h12, 32'd0, -1, 1'b1, 32'hFFFFFF80, 1'b0);
    xact(1'b1, 1'b0, 3'd4, 32'h12, 32'd0, -1, 1'b1, 32'h00000080, 1'b0);
    xact(1'b1, 1'b0, 3'd1, 32'h13, 32'd0, -1, 1'b1, 32'd0, 1'b1);
    xact(1'b0, 1'b1, 3'd2, 32'h20, 32'h11223344, -1, 1'b0, 32'd0, 1'b0);
    xact(1'b0, 1'b1, 3'd2, 32'h22, 32'h55667788, -1, 1'b1, 32'd0, 1'b1);
    xact(1'b1, 1'b0, 3'd2, 32'h20, 32'd0, -1, 1'b1, 32'h11223344, 1'b0);
    xact(1'b0, 1'b1, 3'd2, IO_ADDR, 32'h12345678, -1, 1'b0, 32'd0, 1'b0);
    check("model_io_literal", m_io[0], 32'h12345678);
    xact(1'b0, 1'b1, 3'd1, IO_ADDR + 32'd2, 32'h0000AAAA, -1, 1'b0, 32'd0, 1'b0);
    check("model_io_literal", m_io[0], 32'hAAAA5678);
    xact(1'b1, 1'b0, 3'd2, IO_ADDR, 32'd0, -1, 1'b1, 32'hAAAA5678, 1'b0);
    xact(1'b1, 1'b0, 3'd5, IO_ADDR + 32'd2, 32'd0, -1, 1'b1, 32'h0000AAAA, 1'b0);
    xact(1'b1, 1'b0, 3'd1, IO_ADDR + 32'd2, 32'd0, -1, 1'b1, 32'hFFFFAAAA, 1'b0);
    xact(1'b1, 1'b1, 3'd2, 32'h24, 32'h0F0F0F0F, -1, 1'b1, 32'd0, 1'b0);
    idle_cycle();
    xact(1'b0, 1'b1, 3'd2, 32'h30, 32'h0BADF00D, 1, 1'b0, 32'd0, 1'b0);
    xact(1'b1, 1'b0, 3'd2, 32'h30, 32'd0, -1, 1'b0, 32'd0, 1'b0);
    reset_mid_store(32'h34, 32'hFEEDFACE);
    xact(1'b1, 1'b0, 3'd2, 32'h34, 32'd0, -1, 1'b0, 32'd0, 1'b0);
    idle_cycle();
    random_phase(300);

    sel = 1;
    idle_cycle();
    for (int i = 0; i < 256; i++) xact(1'b0, 1'b1, 3'd2, 32'(i * 4), $urandom, -1, 1'b0, 32'd0, 1'b0);
    xact(1'b0, 1'b1, 3'd2, 32'h8, 32'hCAFEF00D, -1, 1'b0, 32'd0, 1'b0);
    xact(1'b1, 1'b0, 3'd2, 32'h8, 32'd0, -1, 1'b1, 32'hCAFEF00D, 1'b0);
    xact(1'b1, 1'b0, 3'd5, 32'hA, 32'd0, -1, 1'b1, 32'h0000CAFE, 1'b0);
    random_phase(200);

    exp_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
